tetris_cmd_scheduler: RTL
=========================

# tetris_cmd_scheduler

Sequencing front end for the Tetris game logic. It turns raw PS/2 key codes into a single ordered stream of game commands, adds periodic gravity drops, and expands a hard drop into repeated DOWN steps. Commands go out through a valid/ready handshake, so the game logic consumes at most one move per accepted transfer. This block replaces the free-running per-key press counters and the fixed operation-pointer polling.

## Interface
- `GRAVITY_DIV`, default 50_000_000: clk cycles between gravity DOWN requests; legal range 2..2^32-1.
- `DROP_MAX`, default 24: maximum DOWN commands issued per hard drop.
- `clk`  in  1  system clock; all state changes on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `key`  in  3  keyboard code: 0 none, 1 ESC, 2 SPACE, 3 CW, 4 CCW, 5 LEFT, 6 RIGHT, 7 ignored.
- `game_over`  in  1  game logic reports game over (level).
- `landed`  in  1  the current piece cannot move down (level, from the down collision check).
- `cmd_ready`  in  1  game logic accepts `cmd` this cycle.
- `cmd_valid`  out  1  `cmd` holds a command.
- `cmd`  out  3  1 RESET, 3 CW, 4 CCW, 5 LEFT, 6 RIGHT, 7 DOWN. Codes 0 and 2 are never emitted.
- `drop_active`  out  1  a hard drop is in progress.
- `overflow`  out  1  sticky: a key event was lost because the FIFO was full.
- `fifo_count`  out  3  number of occupied FIFO entries, 0..4.

## Operation
- Capture:
  - `key` is registered into k1 and then k2 every cycle.
  - An event occurs when k1 != k2, k1 != 0 and k1 != 7.
  - Events act one edge after detection.
- ESC event:
  - Flushes the FIFO and clears `overflow`, `drop_active` and gravity_pending.
  - Sets esc_pending.
  - If a command is already presented, it is not withdrawn.
- Other events (codes 2..6):
  - Pushed into a 4-entry FIFO.
  - If the FIFO is full, the event is dropped and `overflow` is set, unless a pop happens in the same cycle, in which case the push is accepted and the count is unchanged.
  - While `game_over` is high, these events are discarded and the FIFO is held empty.
- Gravity:
  - A 32-bit counter counts 0..GRAVITY_DIV-1 and wraps.
  - On each wrap it sets gravity_pending, which saturates at one request.
  - The counter is held at 0 while `game_over` or `drop_active` is high.
- Command selection: occurs only when the output is idle (`cmd_valid`=0). Priority, highest first:
  1. esc_pending -> RESET. Clears esc_pending.
  2. `drop_active`:
     - If `landed`=1 or the drop count equals DROP_MAX: clear `drop_active`, emit nothing this cycle.
     - Otherwise emit DOWN and increment the drop count.
  3. gravity_pending and `landed`=0 -> DOWN. Clears gravity_pending. With `landed`=1 the request stays pending.
  4. FIFO not empty: pop the head.
     - SPACE: set `drop_active`, zero the drop count, clear gravity_pending, emit nothing this cycle.
     - Any other code: emit it as `cmd`.
- States:
  - IDLE: `cmd_valid`=0. Selection runs every cycle.
  - ISSUE: `cmd_valid`=1. `cmd` is stable until `cmd_valid`&&`cmd_ready`; then go to IDLE.
  - `drop_active` is an orthogonal flag, not a separate output state.
- Reset mid-operation:
  - Every register returns to its reset value immediately, including a presented command (dropped) and a drop in progress.
  - Reset values: `cmd_valid`=0, `cmd`=0, `drop_active`=0, `overflow`=0, `fifo_count`=0, k1=k2=0, gravity counter=0, esc_pending=0, gravity_pending=0.

## Timing
- Key event latency:
  - `key` changes before edge E0; k1 updates at E0.
  - Push at E1 (`fifo_count` increments).
  - `cmd_valid`=1 after E2, when the FIFO was empty, the output idle and nothing of higher priority is pending.
- Handshake:
  - A transfer occurs at an edge where `cmd_valid`=1 and `cmd_ready`=1.
  - `cmd_valid` is 0 for at least one cycle after every transfer, so at most one command is issued per 2 cycles.
  - `cmd_ready` while `cmd_valid`=0 has no effect.
- SPACE pop costs one idle cycle; the first DOWN appears one cycle later.
- `landed` is sampled only at selection edges.
- Simultaneous ESC event and transfer: the transfer completes, then RESET is presented after the mandatory idle cycle.
- The gravity wrap takes effect on the same edge that sets gravity_pending.

## Test plan
- Reset:
  - Assert `rst_n`=0 asynchronously while `cmd_valid`=1 and `drop_active`=1.
  - Required: all outputs 0 before the next clock edge and `fifo_count`=0.
- Latency and hold:
  - `key`=5 for 3 cycles, `cmd_ready`=0.
  - Required: `cmd_valid`=1, `cmd`=5 from the third edge.
  - Hold `cmd_ready`=0 for 10 cycles, then pulse it: `cmd` stays 5 throughout, and `cmd_valid` drops the cycle after the pulse.
- FIFO overflow:
  - Stimulus: 6 distinct events LEFT, RIGHT, CW, CCW, LEFT, RIGHT with `cmd_ready`=0. The first event moves straight to the output, the next 4 fill the FIFO and the sixth is dropped.
  - Required: `fifo_count`=4 and `overflow`=1.
  - Then tie `cmd_ready`=1. Required order: 5, 6, 3, 4, 5.
- Hard drop:
  - Stimulus: SPACE with `cmd_ready`=1; `landed` rises after the third DOWN transfer.
  - Required: exactly 3 DOWN (7) commands, then `drop_active`=0.
  - Repeat with `landed`=0 throughout: required exactly 24 DOWNs.
- Gravity:
  - Stimulus: `GRAVITY_DIV`=8, `cmd_ready`=1, no keys.
  - Required: one DOWN every 8 cycles.
  - With `landed`=1: no DOWN is issued, and exactly one DOWN follows when `landed` returns to 0.
- ESC and game over:
  - Stimulus: ESC while the FIFO holds 3 entries and `overflow`=1.
  - Required: `fifo_count`=0, `overflow`=0, and the next command is 1.
  - With `game_over`=1: LEFT is ignored, no gravity DOWN is issued, and ESC still yields `cmd`=1.

Source files
------------

// File: rtl/tetris_cmd_scheduler.sv
// Tetris command sequencer: key-event capture, 4-deep command FIFO, gravity ticks and
// hard-drop expansion, merged into one valid/ready command stream.
module tetris_cmd_scheduler #(
   parameter int unsigned GRAVITY_DIV = 50_000_000,
   parameter int unsigned DROP_MAX    = 24
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [2:0] key,
   input  logic       game_over,
   input  logic       landed,
   input  logic       cmd_ready,
   output logic       cmd_valid,
   output logic [2:0] cmd,
   output logic       drop_active,
   output logic       overflow,
   output logic [2:0] fifo_count
);

   localparam int DW = $clog2(DROP_MAX + 2);
   localparam logic [2:0] K_NONE  = 3'd0;
   localparam logic [2:0] K_ESC   = 3'd1;
   localparam logic [2:0] K_SPACE = 3'd2;
   localparam logic [2:0] K_IGN   = 3'd7;
   localparam logic [2:0] C_RESET = 3'd1;
   localparam logic [2:0] C_DOWN  = 3'd7;

   typedef enum logic {IDLE, ISSUE} state_t;

   state_t          state_reg, state_next;
   logic [2:0]      cmd_reg, cmd_next;
   logic [2:0]      k1, k2;
   logic [2:0]      mem [4];
   logic [1:0]      rd_ptr, wr_ptr;
   logic [2:0]      count;
   logic            drop_active_reg, drop_active_next;
   logic [DW-1:0]   drop_cnt, drop_cnt_next;
   logic            overflow_reg;
   logic [31:0]     grav_cnt;
   logic            grav_pending, grav_pending_next;
   logic            esc_pending, esc_pending_next;

   logic            ev, esc_ev, key_ev, full, pop, push, lost, hold_grav, grav_wrap;
   logic [2:0]      head;

   assign ev        = (k1 != k2) && (k1 != K_NONE) && (k1 != K_IGN);
   assign esc_ev    = ev && (k1 == K_ESC);
   assign key_ev    = ev && (k1 != K_ESC) && !game_over;
   assign head      = mem[rd_ptr];
   assign full      = (count == 3'd4);
   // A pop on the same edge frees a slot, so a push into a full FIFO still fits.
   assign push      = key_ev && (!full || pop);
   assign lost      = key_ev && full && !pop;
   assign hold_grav = game_over || drop_active_reg;
   assign grav_wrap = !hold_grav && (grav_cnt == 32'(GRAVITY_DIV - 1));

   always_comb begin
      state_next        = state_reg;
      cmd_next          = cmd_reg;
      drop_active_next  = drop_active_reg;
      drop_cnt_next     = drop_cnt;
      grav_pending_next = grav_pending;
      esc_pending_next  = esc_pending;
      pop               = 1'b0;
      case (state_reg)
         ISSUE: begin
            if (cmd_ready) state_next = IDLE;
         end
         default: begin
            if (esc_pending) begin
               esc_pending_next = 1'b0;
               cmd_next         = C_RESET;
               state_next       = ISSUE;
            end else if (drop_active_reg) begin
               if (landed || (drop_cnt == DW'(DROP_MAX))) begin
                  drop_active_next = 1'b0;
               end else begin
                  drop_cnt_next = drop_cnt + DW'(1);
                  cmd_next      = C_DOWN;
                  state_next    = ISSUE;
               end
            end else if (grav_pending && !landed) begin
               grav_pending_next = 1'b0;
               cmd_next          = C_DOWN;
               state_next        = ISSUE;
            end else if (count != 3'd0) begin
               pop = 1'b1;
               if (head == K_SPACE) begin
                  drop_active_next  = 1'b1;
                  drop_cnt_next     = '0;
                  grav_pending_next = 1'b0;
               end else begin
                  cmd_next   = head;
                  state_next = ISSUE;
               end
            end
         end
      endcase
      if (grav_wrap) grav_pending_next = 1'b1;
      // ESC overrides queued work but never withdraws a command already presented.
      if (esc_ev) begin
         esc_pending_next  = 1'b1;
         drop_active_next  = 1'b0;
         grav_pending_next = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg       <= IDLE;
         cmd_reg         <= 3'd0;
         k1              <= 3'd0;
         k2              <= 3'd0;
         rd_ptr          <= 2'd0;
         wr_ptr          <= 2'd0;
         count           <= 3'd0;
         drop_active_reg <= 1'b0;
         drop_cnt        <= '0;
         overflow_reg    <= 1'b0;
         grav_cnt        <= 32'd0;
         grav_pending    <= 1'b0;
         esc_pending     <= 1'b0;
      end else begin
         state_reg       <= state_next;
         cmd_reg         <= cmd_next;
         k1              <= key;
         k2              <= k1;
         drop_active_reg <= drop_active_next;
         drop_cnt        <= drop_cnt_next;
         grav_pending    <= grav_pending_next;
         esc_pending     <= esc_pending_next;
         if (esc_ev || game_over) begin
            rd_ptr <= 2'd0;
            wr_ptr <= 2'd0;
            count  <= 3'd0;
         end else begin
            if (push) wr_ptr <= wr_ptr + 2'd1;
            if (pop)  rd_ptr <= rd_ptr + 2'd1;
            count <= count + {2'b00, push} - {2'b00, pop};
         end
         if (esc_ev)    overflow_reg <= 1'b0;
         else if (lost) overflow_reg <= 1'b1;
         if (hold_grav || grav_wrap) grav_cnt <= 32'd0;
         else                        grav_cnt <= grav_cnt + 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= k1;
   end

   assign cmd_valid   = (state_reg == ISSUE);
   assign cmd         = cmd_reg;
   assign drop_active = drop_active_reg;
   assign overflow    = overflow_reg;
   assign fifo_count  = count;

endmodule
